mux16_reg: RTL and testbench
============================

Name: mux16_reg

Overview:
- 16-to-1 selector: chooses one of sixteen DATA_W-bit lanes packed on a flat input bus, addressed by a 4-bit select.
- Default build registers the result, giving a clean one-cycle-latency selector for datapath and control muxing.
- A parameter gives a purely combinational build for glue logic.
- Lane k occupies I[k*DATA_W +: DATA_W]; lane 0 is the LSBs.

Parameters:
- DATA_W, 1, width of each input lane and of Q (legal 1..64).
- REG_OUT, 1, 1 = registered output with 1-cycle latency; 0 = combinational output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- I  input  16*DATA_W  packed data lanes; lane k = I[k*DATA_W +: DATA_W].
- sel  input  4  lane select, 0..15.
- en  input  1  capture enable for the output register.
- Q  output  DATA_W  selected lane.
- q_valid  output  1  Q holds a fresh selection.
- sel_q  output  4  select value that produced the current Q.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Selection function: D = I[sel*DATA_W +: DATA_W]. All 16 sel codes are valid; there is no out-of-range case and no default lane.
- REG_OUT=1:
  - rst_n low, at any time and independent of clk: Q=0, sel_q=0, q_valid=0 immediately. Held while rst_n is low.
  - Reset release is synchronous to the next rising edge; the first capture is possible on the first rising edge after rst_n goes high.
  - Rising clk with en=1: Q<=D, sel_q<=sel, q_valid<=1.
  - Rising clk with en=0: Q and sel_q hold; q_valid<=0.
  - Latency: Q reflects the I/sel sampled at the previous edge. Changes to I or sel between edges do not affect Q.
  - Reset mid-stream: Q, sel_q and q_valid clear at once. The pending capture is lost; no stale value reappears after release.
- REG_OUT=0:
  - Q=D combinationally, sel_q=sel, q_valid=en.
  - clk and rst_n are unused; they stay on the port list for a uniform interface.
  - Output follows input within the same delta; no state.
- Every bit of the selected lane propagates independently. Unselected lanes have no effect on Q regardless of value; both walking-0 and walking-1 patterns must pass.
- sel containing X/Z: Q is don't-care for that cycle. No assertion is required.
- No handshake beyond en; there is no backpressure.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with Q nonzero -> Q=0, q_valid=0, sel_q=0 before the next edge. Release, then en=1, I=16'h0001, sel=0 -> Q=1 after one edge.
- Walking-zero/one per lane, DATA_W=1: for k=0..15, apply I=~(1<<k) with sel=k -> Q=0. Then apply I=(1<<k) with sel=k -> Q=1, one cycle later, with sel_q=k. Examples: sel=0 with 16'hFFFE -> 0 and 16'h0001 -> 1; sel=15 with 16'h7FFF -> 0 and 16'h8000 -> 1.
- Isolation: I=16'hFFFF except bit 3 cleared, sel=3 -> Q=0. Same I with sel=4 -> Q=1.
- Enable hold: capture sel=5 with I=16'h0020 (Q=1). Then en=0 while I=0 for 3 cycles -> Q stays 1, q_valid=0. Set en=1 -> Q=0 next edge.
- Wide lanes, DATA_W=8: lane k = 8'h10+k, sweep sel 0..15 -> Q=8'h10..8'h1F in order, each one cycle after its sel.
- REG_OUT=0: change sel 0->15 with I=16'h8000 -> Q goes 0->1 with no clock edge; q_valid tracks en.

Source files
------------

// File: rtl/mux16_reg_if.sv
// mux16_reg_if: lane bus, select, enable and registered result of the 16-to-1 selector
interface mux16_reg_if #(parameter int DATA_W = 1);
  logic [16*DATA_W-1:0] I;
  logic [3:0]           sel;
  logic                 en;
  logic [DATA_W-1:0]    Q;
  logic                 q_valid;
  logic [3:0]           sel_q;
  modport master (output I, sel, en, input Q, q_valid, sel_q);
  modport slave  (input I, sel, en, output Q, q_valid, sel_q);
endinterface

// File: rtl/mux16_reg.sv
// mux16_reg: 16-to-1 lane selector, registered (REG_OUT=1) or combinational (REG_OUT=0)
module mux16_reg #(
  parameter int DATA_W  = 1,
  parameter bit REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mux16_reg_if.slave bus
);
  logic [DATA_W-1:0] d;
  assign d = bus.I[bus.sel*DATA_W +: DATA_W];
  if (REG_OUT) begin : g_reg
    logic [DATA_W-1:0] q_r;
    logic [3:0]        sel_r;
    logic              v_r;
    // q_valid marks a capture on this edge only, so it drops whenever en is low
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        q_r   <= '0;
        sel_r <= '0;
        v_r   <= 1'b0;
      end else begin
        v_r <= bus.en;
        if (bus.en) begin
          q_r   <= d;
          sel_r <= bus.sel;
        end
      end
    assign bus.Q       = q_r;
    assign bus.sel_q   = sel_r;
    assign bus.q_valid = v_r;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign bus.Q          = d;
    assign bus.sel_q      = bus.sel;
    assign bus.q_valid    = bus.en;
  end
endmodule

// File: tb/tb_mux16_reg.sv
// tb_mux16_reg: directed vectors for registered 1-bit, registered 8-bit and combinational builds
module tb_mux16_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  mux16_reg_if #(.DATA_W(1)) b1 ();
  mux16_reg_if #(.DATA_W(8)) b8 ();
  mux16_reg_if #(.DATA_W(1)) bc ();

  mux16_reg #(.DATA_W(1), .REG_OUT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux16_reg #(.DATA_W(8), .REG_OUT(1)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  mux16_reg #(.DATA_W(1), .REG_OUT(0)) uc (.clk(clk), .rst_n(rst_n), .bus(bc));

  typedef struct {
    logic [15:0] i;
    logic [3:0]  sel;
    logic        en;
    logic        exp_q;
    logic        exp_v;
    logic [3:0]  exp_sel;
  } vec_t;
  vec_t vt[34];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic q, input logic v, input logic [3:0] s);
    chk({name, ".Q"}, 64'(b1.Q), 64'(q));
    chk({name, ".q_valid"}, 64'(b1.q_valid), 64'(v));
    chk({name, ".sel_q"}, 64'(b1.sel_q), 64'(s));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      vt[2*k]   = '{i: ~(16'h1 << k), sel: 4'(k), en: 1'b1, exp_q: 1'b0, exp_v: 1'b1, exp_sel: 4'(k)};
      vt[2*k+1] = '{i: 16'h1 << k,    sel: 4'(k), en: 1'b1, exp_q: 1'b1, exp_v: 1'b1, exp_sel: 4'(k)};
    end
    vt[32] = '{i: 16'hFFF7, sel: 4'd3, en: 1'b1, exp_q: 1'b0, exp_v: 1'b1, exp_sel: 4'd3};
    vt[33] = '{i: 16'hFFF7, sel: 4'd4, en: 1'b1, exp_q: 1'b1, exp_v: 1'b1, exp_sel: 4'd4};
    b1.I = '0; b1.sel = '0; b1.en = 1'b0;
    b8.I = '0; b8.sel = '0; b8.en = 1'b0;
    bc.I = '0; bc.sel = '0; bc.en = 1'b0;
    // reset state, held across edges
    b1.I = 16'hFFFF; b1.en = 1'b1;
    #22;
    chk1("rst_hold", 1'b0, 1'b0, 4'd0);
    chk("rst_hold8.Q", 64'(b8.Q), 64'h0);
    // release mid-cycle, first edge after release captures
    @(negedge clk);
    rst_n = 1'b1;
    b1.I = 16'h0001; b1.sel = 4'd0; b1.en = 1'b1;
    tick();
    chk1("first_cap", 1'b1, 1'b1, 4'd0);
    // asynchronous reset mid-cycle with Q and sel_q nonzero
    b1.I = 16'h0020; b1.sel = 4'd5;
    tick();
    chk1("pre_rst", 1'b1, 1'b1, 4'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async_rst", 1'b0, 1'b0, 4'd0);
    tick();
    chk1("rst_edge", 1'b0, 1'b0, 4'd0);
    #3;
    rst_n = 1'b1;
    b1.I = 16'h0000; b1.sel = 4'd2;
    tick();
    chk1("post_rst", 1'b0, 1'b1, 4'd2);
    // walking zero/one and isolation table
    foreach (vt[n]) begin
      b1.I = vt[n].i; b1.sel = vt[n].sel; b1.en = vt[n].en;
      tick();
      chk1($sformatf("vec%0d", n), vt[n].exp_q, vt[n].exp_v, vt[n].exp_sel);
    end
    // inputs changing between edges must not reach Q
    b1.I = 16'h0000; b1.sel = 4'd0;
    #2;
    chk1("between_edges", 1'b1, 1'b1, 4'd4);
    // enable hold
    b1.I = 16'h0020; b1.sel = 4'd5; b1.en = 1'b1;
    tick();
    chk1("hold_cap", 1'b1, 1'b1, 4'd5);
    b1.I = 16'h0000; b1.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk1($sformatf("hold%0d", c), 1'b1, 1'b0, 4'd5);
    end
    b1.en = 1'b1;
    tick();
    chk1("hold_release", 1'b0, 1'b1, 4'd5);
    // 8-bit lanes
    for (int k = 0; k < 16; k++) b8.I[k*8 +: 8] = 8'(8'h10 + k);
    b8.en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      b8.sel = 4'(k);
      #1;
      if (k > 0) chk($sformatf("w8_lat%0d", k), 64'(b8.Q), 64'(8'h10 + k - 1));
      tick();
      chk($sformatf("w8_q%0d", k), 64'(b8.Q), 64'(8'h10 + k));
      chk($sformatf("w8_sel%0d", k), 64'(b8.sel_q), 64'(k));
    end
    // combinational build, checked away from any dependency on clk
    @(negedge clk);
    bc.I = 16'h8000; bc.sel = 4'd0; bc.en = 1'b1;
    #1;
    chk("comb_q0", 64'(bc.Q), 64'h0);
    bc.sel = 4'd15;
    #1;
    chk("comb_q15", 64'(bc.Q), 64'h1);
    chk("comb_sel", 64'(bc.sel_q), 64'hF);
    chk("comb_v1", 64'(bc.q_valid), 64'h1);
    bc.en = 1'b0;
    #1;
    chk("comb_v0", 64'(bc.q_valid), 64'h0);
    bc.I = 16'h7FFF;
    #1;
    chk("comb_iso", 64'(bc.Q), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
